cpri_rx_unpkg: RTL and testbench

CPRI_RX_UNPKG -- requirements
Module: cpri_rx_unpkg

---
 rtl/cpri_rx_unpkg.sv | 151 +++++++++++++++
 tb/tb_cpri_rx_unpkg.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_rx_unpkg.sv
// CPRI IQ receive unpacker: strips per-type padding from fixed 96-word frames and emits packets.
// Optional header stripping (words 0..2) is enabled by defining CPRI_RX_HDR_STRIP_EN.
module cpri_rx_unpkg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_iq_rx_valid,
   input  logic [63:0] i_iq_rx_data,
   input  logic [3:0]  i_data_type,
   output logic        o_vld,
   output logic        o_sop,
   output logic        o_eop,
   output logic [63:0] o_data,
   output logic        o_abort,
   output logic [15:0] o_frame_cnt
);

   localparam logic [6:0] LastIdx = 7'd95;
`ifdef CPRI_RX_HDR_STRIP_EN
   localparam logic [6:0] HdrLen = 7'd3;
`else
   localparam logic [6:0] HdrLen = 7'd0;
`endif

   typedef enum logic [1:0] {StIdle, StRecv, StPad, StErr} state_e;

   state_e      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [3:0]  type_q, type_d;

   logic        vld_d, sop_d, eop_d, abort_d;
   logic [63:0] data_d;
   logic [15:0] fcnt_d;

   logic [6:0]  idx, cur_last;
   logic        past_hdr, pkt_started, in_pkt, frame_done;

   // Index of the last forwarded word; clipped to the frame end when the header shifts it out.
   function automatic logic [6:0] last_idx(input logic [3:0] t);
      logic [7:0] l;
      case (t)
         4'd1:    l = 8'd53;
         4'd2:    l = 8'd35;
         4'd3:    l = 8'd83;
         4'd4:    l = 8'd59;
         default: l = 8'd96;
      endcase
      l = l + {1'b0, HdrLen} - 8'd1;
      if (l > {1'b0, LastIdx}) l = {1'b0, LastIdx};
      return l[6:0];
   endfunction

   assign idx      = (state_q == StIdle) ? 7'd0 : cnt_q;
   assign cur_last = (state_q == StIdle) ? last_idx(i_data_type) : last_idx(type_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 7'd0;
         type_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      unique case (state_q)
         StIdle: begin
            if (i_iq_rx_valid) begin
               type_d  = i_data_type;
               cnt_d   = 7'd1;
               state_d = StRecv;
            end
         end
         StRecv: begin
            if (!i_iq_rx_valid) begin
               state_d = StErr;
               cnt_d   = 7'd0;
            end else if (cnt_q == cur_last) begin
               if (cnt_q == LastIdx) begin
                  state_d = StIdle;
                  cnt_d   = 7'd0;
               end else begin
                  state_d = StPad;
                  cnt_d   = cnt_q + 7'd1;
               end
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         StPad: begin
            if (!i_iq_rx_valid) begin
               state_d = StErr;
               cnt_d   = 7'd0;
            end else if (cnt_q == LastIdx) begin
               state_d = StIdle;
               cnt_d   = 7'd0;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         StErr: begin
            if (!i_iq_rx_valid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
`ifdef CPRI_RX_HDR_STRIP_EN
      past_hdr    = (idx >= HdrLen);
      pkt_started = (cnt_q > HdrLen);
`else
      past_hdr    = 1'b1;
      pkt_started = 1'b1;
`endif
      in_pkt     = i_iq_rx_valid && (state_q == StIdle || state_q == StRecv) &&
                   past_hdr && (idx <= cur_last);
      vld_d      = in_pkt;
      sop_d      = in_pkt && (idx == HdrLen);
      eop_d      = in_pkt && (idx == cur_last);
      data_d     = in_pkt ? i_iq_rx_data : 64'd0;
      // A truncated packet is only reported once its SOP has actually gone out.
      abort_d    = (state_q == StRecv) && !i_iq_rx_valid && pkt_started;
      frame_done = i_iq_rx_valid && (state_q == StRecv || state_q == StPad) && (cnt_q == LastIdx);
      fcnt_d     = o_frame_cnt + {15'd0, frame_done};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld       <= 1'b0;
         o_sop       <= 1'b0;
         o_eop       <= 1'b0;
         o_data      <= 64'd0;
         o_abort     <= 1'b0;
         o_frame_cnt <= 16'd0;
      end else begin
         o_vld       <= vld_d;
         o_sop       <= sop_d;
         o_eop       <= eop_d;
         o_data      <= data_d;
         o_abort     <= abort_d;
         o_frame_cnt <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_cpri_rx_unpkg.sv
// Scoreboard bench for cpri_rx_unpkg: a frame-level model queues expected words, aborts and
// frame counts with their due cycle; a monitor pops and compares on every output cycle.
module tb_cpri_rx_unpkg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_iq_rx_valid;
   logic [63:0] i_iq_rx_data;
   logic [3:0]  i_data_type;
   logic        o_vld, o_sop, o_eop, o_abort;
   logic [63:0] o_data;
   logic [15:0] o_frame_cnt;

`ifdef CPRI_RX_HDR_STRIP_EN
   localparam int Hdr = 3;
`else
   localparam int Hdr = 0;
`endif

   cpri_rx_unpkg dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_iq_rx_valid (i_iq_rx_valid),
      .i_iq_rx_data  (i_iq_rx_data),
      .i_data_type   (i_data_type),
      .o_vld         (o_vld),
      .o_sop         (o_sop),
      .o_eop         (o_eop),
      .o_data        (o_data),
      .o_abort       (o_abort),
      .o_frame_cnt   (o_frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [31:0] stamp;
   } exp_t;

   typedef struct packed {
      logic [15:0] val;
      logic [31:0] stamp;
   } fc_t;

   exp_t        exp_q[$];
   int unsigned ab_q[$];
   fc_t         fc_q[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] model_fc = 16'd0;
   logic [15:0] exp_fc = 16'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pay_len(input int t);
      case (t)
         1:       return 53;
         2:       return 35;
         3:       return 83;
         4:       return 59;
         default: return 96;
      endcase
   endfunction

   // Monitor: everything here is driven by the expected queues, never by DUT internals.
   always @(negedge clk) begin
      if (rst_n) begin
         while (fc_q.size() > 0 && fc_q[0].stamp <= cyc) exp_fc = fc_q.pop_front().val;
         chk("frame_cnt", {48'd0, o_frame_cnt}, {48'd0, exp_fc});
         if (o_vld) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_vld", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("data", o_data, e.d);
               chk("sop", {63'd0, o_sop}, {63'd0, e.sop});
               chk("eop", {63'd0, o_eop}, {63'd0, e.eop});
               chk("latency", {32'd0, cyc}, {32'd0, e.stamp});
            end
         end else begin
            chk("data_idle_zero", o_data, 64'd0);
         end
         if (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
            chk("missing_word", {32'd0, cyc}, {32'd0, exp_q[0].stamp});
            void'(exp_q.pop_front());
         end
         if (o_abort) begin
            if (ab_q.size() == 0) chk("unexpected_abort", 64'd1, 64'd0);
            else chk("abort_time", {32'd0, cyc}, {32'd0, ab_q.pop_front()});
         end else if (ab_q.size() > 0 && ab_q[0] < cyc) begin
            chk("missing_abort", {32'd0, cyc}, {32'd0, ab_q[0]});
            void'(ab_q.pop_front());
         end
      end
   end

   task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] t);
      @(negedge clk);
      i_iq_rx_valid = v;
      i_iq_rx_data  = d;
      i_data_type   = t;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, {$urandom, $urandom}, 4'($urandom));
   endtask

   // One frame of type t. drop_at >= 1 drops valid at that index, then sends junk valid words
   // (dropped in the error state) and one idle cycle. rst_at >= 1 resets at that index instead.
   task automatic send_frame(input int t, input int drop_at, input int junk, input int rst_at,
                             input bit idx_data);
      int first, last;
      logic [63:0] d;
      exp_t e;
      fc_t f;
      first = Hdr;
      last  = Hdr + pay_len(t) - 1;
      if (last > 95) last = 95;
      for (int i = 0; i < 96; i++) begin
         if (i == rst_at) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            i_iq_rx_valid = 1'b0;
            #1;
            chk("rst_vld", {63'd0, o_vld}, 64'd0);
            chk("rst_sop_eop", {62'd0, o_sop, o_eop}, 64'd0);
            chk("rst_data", o_data, 64'd0);
            chk("rst_abort", {63'd0, o_abort}, 64'd0);
            chk("rst_frame_cnt", {48'd0, o_frame_cnt}, 64'd0);
            chk("rst_pending", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            ab_q.delete();
            fc_q.delete();
            model_fc = 16'd0;
            exp_fc   = 16'd0;
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            return;
         end
         if (i == drop_at) begin
            drive(1'b0, {$urandom, $urandom}, 4'($urandom));
            if (i > first && i <= last) ab_q.push_back(cyc + 1);
            for (int j = 0; j < junk; j++) drive(1'b1, {$urandom, $urandom}, 4'($urandom));
            drive(1'b0, 64'd0, 4'($urandom));
            return;
         end
         d = idx_data ? 64'(i) : {$urandom, $urandom};
         drive(1'b1, d, (i == 0) ? 4'(t) : 4'($urandom));
         if (i >= first && i <= last) begin
            e.d = d; e.sop = (i == first); e.eop = (i == last); e.stamp = cyc + 1;
            exp_q.push_back(e);
         end
         if (i == 95) begin
            model_fc = model_fc + 16'd1;
            f.val = model_fc; f.stamp = cyc + 1;
            fc_q.push_back(f);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int types[7];
      types = '{0, 1, 2, 3, 4, 5, 15};
      rst_n = 1'b0;
      i_iq_rx_valid = 1'b0;
      i_iq_rx_data  = 64'd0;
      i_data_type   = 4'd0;
      #1;
      chk("init_vld", {63'd0, o_vld}, 64'd0);
      chk("init_data", o_data, 64'd0);
      chk("init_frame_cnt", {48'd0, o_frame_cnt}, 64'd0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(2);

      send_frame(2, -1, 0, -1, 1'b1);
      idle(1);
      send_frame(1, -1, 0, -1, 1'b1);
      send_frame(3, -1, 0, -1, 1'b1);
      idle(2);
      send_frame(4, 20, 0, -1, 1'b1);
      send_frame(4, -1, 0, -1, 1'b0);
      send_frame(2, 60, 3, -1, 1'b0);
      send_frame(5, -1, 0, -1, 1'b1);
      idle(3);
      send_frame(3, -1, 0, 40, 1'b1);
      idle(1);
      send_frame(3, -1, 0, -1, 1'b1);

      for (int n = 0; n < 30; n++) begin
         int t, drop;
         t = types[$urandom_range(0, 6)];
         drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 95) : -1;
         send_frame(t, drop, $urandom_range(0, 3), -1, 1'b0);
         idle($urandom_range(0, 2));
      end

      idle(5);
      chk("drain_words", 64'(exp_q.size()), 64'd0);
      chk("drain_aborts", 64'(ab_q.size()), 64'd0);
      chk("final_frame_cnt", {48'd0, o_frame_cnt}, {48'd0, model_fc});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
